// File: rtl/mem_arbiter_pkg.sv
// Shared constants and helpers for the multi-port memory arbiter.
package mem_arbiter_pkg;

  localparam int MAX_PORTS = 8;

  // Width of an index able to address up to MAX_PORTS requesters.
  function automatic int clog2_ports(input int n);
    if (n <= 2) return 1;
    else if (n <= 4) return 2;
    else return 3;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational winner selection: rotating search from a start index, or
// lowest-index-wins when round-robin is disabled.
module rr_picker #(
  parameter int NUM_PORTS = 3,
  parameter int IDX_WIDTH = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_WIDTH-1:0] start,
  input  logic                 round_robin,
  output logic [NUM_PORTS-1:0] winner
);

  logic                 found;
  logic [IDX_WIDTH-1:0] idx;

  // Walk the ports in search order; the first requester seen becomes the winner.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = IDX_WIDTH'(((round_robin ? int'(start) : 0) + k) % NUM_PORTS);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_port_mem_arbiter.sv
// Arbitrates several memory masters onto one downstream port; a grant is held
// until the downstream acks or the granted master withdraws its request.
module multi_port_mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_PORTS   = 3,
  parameter int ADDR_WIDTH  = 19,
  parameter int DATA_WIDTH  = 16,
  parameter int ROUND_ROBIN = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   m_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   m_data_out,
  output logic [DATA_WIDTH-1:0]             m_data_in,
  input  logic [NUM_PORTS-1:0]              m_access,
  output logic [NUM_PORTS-1:0]              m_ack,
  input  logic [NUM_PORTS-1:0]              m_wr_en,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] m_bytesel,
  output logic [ADDR_WIDTH-1:0]             q_m_addr,
  output logic [DATA_WIDTH-1:0]             q_m_data_out,
  output logic                              q_m_wr_en,
  output logic [DATA_WIDTH/8-1:0]           q_m_bytesel,
  output logic                              q_m_access,
  input  logic                              q_m_ack,
  input  logic [DATA_WIDTH-1:0]             q_m_data_in,
  output logic                              busy
);

  localparam int IDX_WIDTH = clog2_ports(NUM_PORTS);
  localparam int BYTES     = DATA_WIDTH / 8;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_PORTS - 1);

  logic [NUM_PORTS-1:0] grant;
  logic [NUM_PORTS-1:0] winner;
  logic [NUM_PORTS-1:0] sel;
  logic [IDX_WIDTH-1:0] last_grant;
  logic [IDX_WIDTH-1:0] pick_start;
  logic [IDX_WIDTH-1:0] winner_idx;

  assign pick_start = (last_grant == LAST_IDX) ? '0 : last_grant + 1'b1;

  rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_picker (
    .req         (m_access),
    .start       (pick_start),
    .round_robin (ROUND_ROBIN != 0),
    .winner      (winner)
  );

  // A held grant freezes selection; otherwise the fresh winner drives q_* at once.
  always_comb begin
    sel = '0;
    if (reset) sel = (grant != '0) ? grant : winner;
  end

  always_comb begin
    q_m_addr     = '0;
    q_m_data_out = '0;
    q_m_wr_en    = 1'b0;
    q_m_bytesel  = '0;
    q_m_access   = 1'b0;
    winner_idx   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      q_m_addr     = q_m_addr | (m_addr[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{sel[i]}});
      q_m_data_out = q_m_data_out | (m_data_out[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{sel[i]}});
      q_m_bytesel  = q_m_bytesel | (m_bytesel[i*BYTES +: BYTES] & {BYTES{sel[i]}});
      q_m_wr_en    = q_m_wr_en | (m_wr_en[i] & sel[i]);
      q_m_access   = q_m_access | (m_access[i] & sel[i]);
      winner_idx   = winner_idx | (IDX_WIDTH'(i) & {IDX_WIDTH{winner[i]}});
    end
  end

  assign m_ack     = grant & {NUM_PORTS{q_m_ack}};
  assign m_data_in = q_m_data_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant      <= '0;
      busy       <= 1'b0;
      last_grant <= LAST_IDX;
    end else if (grant == '0) begin
      if (winner != '0) begin
        grant      <= winner;
        busy       <= 1'b1;
        last_grant <= winner_idx;
      end
    end else if (q_m_ack || ((grant & m_access) == '0)) begin
      grant <= '0;
      busy  <= 1'b0;
    end
  end

endmodule
